// File: rtl/outerprodrc_pkg.sv
// Shared definitions for the outer-product array and its controller:
// operand width, operand-pair count width, accumulation window and FSM encodings.
package outerprodrc_pkg;

    localparam int DEF_BITWIDTH = 8;
    localparam int DEF_KWIDTH   = 8;
    localparam int DEF_WIN      = 1 << (DEF_BITWIDTH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    // The stochastic window length follows from the sign-magnitude operand width.
    function automatic int win_of(input int bitwidth);
        return 1 << (bitwidth - 1);
    endfunction

endpackage

// File: rtl/outerprodrc_ctrl.sv
// Job controller for the outer-product array: fetches K operand-vector pairs,
// runs the array for one accumulation window each and hands every result downstream.
module outerprodrc_ctrl
    import outerprodrc_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int KWIDTH   = DEF_KWIDTH
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iStart,
    input  logic [KWIDTH-1:0] iKLen,
    input  logic              iAbort,
    input  logic              iOpVld,
    output logic              oOpRdy,
    output logic              oLoad,
    output logic              oArrClr,
    output logic              oArrEn,
    output logic              oResVld,
    input  logic              iResRdy,
    output logic [KWIDTH-1:0] oKIdx,
    output logic              oBusy,
    output logic              oDone
);

    localparam int                WIN      = win_of(BITWIDTH);
    localparam logic [BITWIDTH-1:0] WIN_LAST = BITWIDTH'(WIN - 1);

    logic [1:0]          state;
    logic [KWIDTH-1:0]   k_len;
    logic [KWIDTH-1:0]   k_idx;
    logic [BITWIDTH-1:0] win_cnt;
    logic                done_q;

    logic abort_act;
    logic load_act;
    logic last_pair;

    // Abort only matters once a job is running, and it overrides every other input.
    assign abort_act = iAbort && (state != ST_IDLE);
    assign load_act  = (state == ST_FETCH) && iOpVld && !iAbort;
    assign last_pair = (k_idx == k_len - KWIDTH'(1));

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state   <= ST_IDLE;
            k_len   <= '0;
            k_idx   <= '0;
            win_cnt <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_act) begin
                state   <= ST_IDLE;
                k_idx   <= '0;
                win_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (iStart) begin
                            if (iKLen != '0) begin
                                k_len <= iKLen;
                                k_idx <= '0;
                                state <= ST_FETCH;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (iOpVld) begin
                            win_cnt <= '0;
                            state   <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            state   <= ST_RESULT;
                        end else begin
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
                    ST_RESULT: begin
                        if (iResRdy) begin
                            if (last_pair) begin
                                done_q <= 1'b1;
                                state  <= ST_IDLE;
                            end else begin
                                k_idx <= k_idx + 1'b1;
                                state <= ST_FETCH;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Handshake outputs decode from state so reset forces them low immediately.
    assign oOpRdy  = (state == ST_FETCH) && !iAbort;
    assign oLoad   = load_act;
    assign oArrClr = load_act || abort_act;
    assign oArrEn  = (state == ST_RUN);
    assign oResVld = (state == ST_RESULT);
    assign oKIdx   = k_idx;
    assign oBusy   = (state != ST_IDLE);
    assign oDone   = done_q;

endmodule

// File: tb/tb_outerprodrc_ctrl.sv
// Scoreboard bench for outerprodrc_ctrl: directed jobs push expected results,
// a negedge monitor pops and compares whenever the controller presents one.
module tb_outerprodrc_ctrl;
    import outerprodrc_pkg::*;

    localparam int KW   = DEF_KWIDTH;
    localparam int WINC = 128;

    logic          iClk = 1'b0;
    logic          iRstN;
    logic          iStart;
    logic [KW-1:0] iKLen;
    logic          iAbort;
    logic          iOpVld;
    logic          oOpRdy;
    logic          oLoad;
    logic          oArrClr;
    logic          oArrEn;
    logic          oResVld;
    logic          iResRdy;
    logic [KW-1:0] oKIdx;
    logic          oBusy;
    logic          oDone;

    outerprodrc_ctrl dut (
        .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iKLen(iKLen),
        .iAbort(iAbort), .iOpVld(iOpVld), .oOpRdy(oOpRdy), .oLoad(oLoad),
        .oArrClr(oArrClr), .oArrEn(oArrEn), .oResVld(oResVld),
        .iResRdy(iResRdy), .oKIdx(oKIdx), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        int kidx;
        int en_cycles;
    } res_t;

    res_t exp_res[$];
    int   exp_done[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [KW-1:0] klen);
        iStart = 1'b1;
        iKLen  = klen;
        tick();
        iStart = 1'b0;
    endtask

    task automatic push_job(input int k);
        for (int i = 0; i < k; i++) exp_res.push_back(res_t'{kidx: i, en_cycles: WINC});
        exp_done.push_back(1);
    endtask

    // Monitor: tracks enable cycles per pair, checks held results and invariants.
    int            en_cnt    = 0;
    logic          prev_hold = 1'b0;
    logic [KW-1:0] prev_kidx = '0;

    always @(negedge iClk) begin
        res_t r;
        if (oLoad) en_cnt = 0;
        else if (oArrEn) en_cnt++;
        if (oBusy)
            check_output("exclusive", 32'({oArrEn & oResVld, oOpRdy & oArrEn, oOpRdy & oResVld,
                                           oLoad & ~oOpRdy, oArrClr & ~(oLoad | iAbort)}), 0);
        if (prev_hold && iRstN) begin
            check_output("res_hold_vld", 32'(oResVld), 1);
            check_output("res_hold_kidx", 32'(oKIdx), 32'(prev_kidx));
        end
        prev_hold = oResVld & ~iResRdy & ~iAbort;
        prev_kidx = oKIdx;
        if (oResVld && iResRdy && !iAbort) begin
            check_output("res_expected", 32'(exp_res.size() > 0), 1);
            if (exp_res.size() > 0) begin
                r = exp_res.pop_front();
                check_output("res_kidx", 32'(oKIdx), r.kidx);
                check_output("res_en_cycles", en_cnt, r.en_cycles);
            end
        end
        if (oDone) begin
            check_output("done_expected", 32'(exp_done.size() > 0), 1);
            if (exp_done.size() > 0) void'(exp_done.pop_front());
        end
    end

    initial begin
        int n, busy, loads, seen_en, seen_rdy, held, seen_done;
        iRstN = 1'b0; iStart = 1'b0; iAbort = 1'b0;
        iOpVld = 1'b0; iResRdy = 1'b0; iKLen = '0;
        #3;
        check_output("reset_outs", 32'({oOpRdy, oLoad, oArrClr, oArrEn, oResVld, oBusy, oDone}), 0);
        check_output("reset_kidx", 32'(oKIdx), 0);
        tick(); tick();
        iRstN = 1'b1;
        tick();

        // Full job of three pairs with upstream and downstream always ready.
        iOpVld = 1'b1; iResRdy = 1'b1;
        push_job(3);
        apply_stimulus(3);
        busy = 0; loads = 0; n = 0;
        while (oBusy && n < 2000) begin
            if (oLoad) begin
                check_output("t1_kidx_at_load", 32'(oKIdx), loads);
                loads++;
            end
            busy++; n++;
            tick();
        end
        check_output("t1_busy_cycles", busy, 390);
        check_output("t1_loads", loads, 3);
        check_output("t1_done_now", 32'(oDone), 1);
        tick();
        check_output("t1_done_end", 32'(oDone), 0);

        // Zero-length job: done pulse only.
        iOpVld = 1'b0; iResRdy = 1'b0;
        exp_done.push_back(1);
        apply_stimulus(0);
        check_output("t2_done", 32'(oDone), 1);
        check_output("t2_busy", 32'(oBusy), 0);
        check_output("t2_ctrl", 32'({oLoad, oArrEn, oArrClr}), 0);
        tick();
        check_output("t2_done_end", 32'(oDone), 0);
        check_output("t2_ctrl_end", 32'({oLoad, oArrEn, oArrClr}), 0);

        // Stalls on both sides of the pair.
        push_job(1);
        apply_stimulus(1);
        seen_en = 0; seen_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            seen_en  += int'(oArrEn);
            seen_rdy += int'(oOpRdy);
            tick();
        end
        check_output("t3_fetch_en", seen_en, 0);
        check_output("t3_fetch_rdy", seen_rdy, 10);
        iOpVld = 1'b1;
        tick();
        iOpVld = 1'b0;
        n = 0;
        while (!oResVld && n < 300) begin
            n++;
            tick();
        end
        check_output("t3_run_len", n, WINC);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            held += int'(oResVld && !oArrEn);
            tick();
        end
        check_output("t3_res_held", held, 5);
        iResRdy = 1'b1;
        tick();
        iResRdy = 1'b0;
        check_output("t3_idle", 32'(oBusy), 0);
        check_output("t3_done", 32'(oDone), 1);

        // Abort at RUN cycle 50 of pair 1, then restart.
        iOpVld = 1'b1; iResRdy = 1'b1;
        exp_res.push_back(res_t'{kidx: 0, en_cycles: WINC});
        apply_stimulus(4);
        n = 0;
        while (!(oKIdx == 1 && oArrEn) && n < 500) begin
            n++;
            tick();
        end
        check_output("t4_reach_pair1", 32'(n < 500), 1);
        repeat (49) tick();
        iAbort = 1'b1;
        #1;
        check_output("t4_abort_clr", 32'(oArrClr), 1);
        tick();
        iAbort = 1'b0;
        check_output("t4_idle", 32'(oBusy), 0);
        check_output("t4_clr_end", 32'(oArrClr), 0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            seen_done += int'(oDone);
            tick();
        end
        check_output("t4_no_done", seen_done, 0);
        push_job(1);
        apply_stimulus(1);
        check_output("t4_restart_kidx", 32'(oKIdx), 0);
        check_output("t4_restart_busy", 32'(oBusy), 1);
        n = 0;
        while (oBusy && n < 300) begin
            n++;
            tick();
        end
        check_output("t4_restart_len", n, WINC + 2);

        // Ignored start while busy, then asynchronous reset at RUN cycle 64.
        apply_stimulus(2);
        n = 0;
        while (!oArrEn && n < 20) begin
            n++;
            tick();
        end
        check_output("t5_run", 32'(oArrEn), 1);
        iStart = 1'b1; iKLen = 8'd5;
        tick();
        iStart = 1'b0;
        check_output("t5_start_ignored_kidx", 32'(oKIdx), 0);
        check_output("t5_start_ignored_en", 32'(oArrEn), 1);
        repeat (62) tick();
        #2;
        iRstN = 1'b0;
        #1;
        check_output("t5_reset_outs", 32'({oOpRdy, oLoad, oArrClr, oArrEn, oResVld, oBusy, oDone}), 0);
        check_output("t5_reset_kidx", 32'(oKIdx), 0);
        tick(); tick();
        iRstN = 1'b1;
        tick();
        check_output("t5_idle", 32'(oBusy), 0);

        // Window counter must restart cleanly after the reset.
        push_job(1);
        apply_stimulus(1);
        n = 0;
        while (oBusy && n < 300) begin
            n++;
            tick();
        end
        check_output("t5_post_len", n, WINC + 2);
        repeat (3) tick();
        check_output("res_queue_empty", exp_res.size(), 0);
        check_output("done_queue_empty", exp_done.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/outerprodrc_ctrl.md
OUTERPRODRC_CTRL -- requirements
Module: outerprodrc_ctrl

Interface
REQ-001 Parameter BITWIDTH, default 8, operand width in sign-magnitude format; accumulation window WIN = 2^(BITWIDTH-1) cycles.
REQ-002 Parameter KWIDTH, default 8, width of the operand-pair count and index.
REQ-003 iClk  in  1  sole clock; all state updates on its rising edge.
REQ-004 iRstN  in  1  reset, asynchronous, active-low.
REQ-005 iStart  in  1  job start pulse; sampled only in IDLE.
REQ-006 iKLen  in  KWIDTH  number of operand-vector pairs in the job; latched on accepted iStart.
REQ-007 iAbort  in  1  synchronous job abort.
REQ-008 iOpVld  in  1  an operand row/column vector pair is available upstream.
REQ-009 oOpRdy  out  1  controller accepts the operand pair; transfer occurs when iOpVld & oOpRdy.
REQ-010 oLoad  out  1  one-cycle strobe loading the operand registers that feed the array's iData0/iData1.
REQ-011 oArrClr  out  1  drives the array's iClr, clearing its accumulators and RNGs.
REQ-012 oArrEn  out  1  drives the array's iEn.
REQ-013 oResVld  out  1  array oData holds the final result for the current pair.
REQ-014 iResRdy  in  1  downstream accepts the result; transfer occurs when oResVld & iResRdy.
REQ-015 oKIdx  out  KWIDTH  index of the pair currently being processed.
REQ-016 oBusy  out  1  high in every state except IDLE.
REQ-017 oDone  out  1  one-cycle pulse at normal job completion.

Function
REQ-018 States: IDLE, FETCH, RUN, RESULT; encoding is implementation-defined.
REQ-019 IDLE: iStart=1 with iKLen!=0 latches K=iKLen, sets oKIdx=0, and moves to FETCH.
REQ-020 IDLE: iStart=1 with iKLen=0 pulses oDone on the next cycle, stays in IDLE, and asserts no array control.
REQ-021 FETCH: oOpRdy=1; on handshake, oLoad=1 and oArrClr=1 in that same cycle, then move to RUN; otherwise wait indefinitely.
REQ-022 RUN: oArrEn=1 for exactly WIN consecutive cycles, counted by a BITWIDTH-bit window counter, then move to RESULT.
REQ-023 RESULT: oResVld=1 and oArrEn=0, held until handshake; oResVld is never withdrawn without a handshake, except on abort.
REQ-024 RESULT handshake with oKIdx=K-1: oDone=1 for one cycle and return to IDLE.
REQ-025 RESULT handshake otherwise: increment oKIdx and go to FETCH.
REQ-026 Latency: handshake at cycle t gives oArrEn high in cycles t+1..t+WIN and oResVld first high at t+WIN+1.
REQ-027 oOpRdy, oArrEn, oResVld and oLoad are mutually exclusive except oLoad with oOpRdy; oArrClr is high only with oLoad or abort.
REQ-028 iStart while busy is ignored; K and oKIdx are unaffected.
REQ-029 iAbort in any non-IDLE state: next state IDLE, oArrClr=1 for one cycle, no oDone; iAbort has priority over all other inputs; iAbort in IDLE is ignored.
REQ-030 Window counter and oKIdx do not wrap within a job; K=2^KWIDTH-1 is the maximum job length.

Reset
REQ-031 Asserting iRstN low at any time, including mid-RUN, forces IDLE; oKIdx=0, window counter=0, and all outputs=0 asynchronously.
REQ-032 After reset release, the first legal action is an iStart in IDLE.

Structure
REQ-033 BITWIDTH, KWIDTH, WIN and state encodings live in the shared definitions file used by the outer-product array.
REQ-034 Single module, no sub-modules; the controller instantiates neither the array nor the RNGs; the integrator wires oArrEn/oArrClr to the array's iEn/iClr.

Verification (BITWIDTH=8, WIN=128)
REQ-035 iKLen=3, iOpVld and iResRdy held high: 3 oLoad strobes; each followed by exactly 128 oArrEn cycles; oKIdx steps 0,1,2; one oDone pulse; oBusy is high for 3*130 cycles.
REQ-036 iKLen=0 start: oDone pulse one cycle later; oArrEn, oArrClr and oLoad stay 0.
REQ-037 iOpVld low for 10 cycles in FETCH, then iResRdy low for 5 cycles in RESULT: controller stalls; no extra oArrEn; oResVld is held steady for 5 cycles.
REQ-038 iAbort at RUN cycle 50 of pair 1 (iKLen=4): oArrClr pulse, IDLE next cycle, no oDone; a following iStart restarts at oKIdx=0.
REQ-039 iRstN low at RUN cycle 64: all outputs 0 immediately; iStart pulses during a job are ignored.
REQ-040 End-to-end with an outerprodrc model, data0=0x40, data1=0x40 (both 0.5): after 128 cycles the result magnitude is 32 +/- 1 and the sign is 0.
